// File: rtl/ex_mem_stage_pkg.sv
// ex_mem_stage_pkg
//   Shared types for the EX/MEM pipeline stage of the RV32-APX core.
//   - EX_DATA_W       : default datapath width (ALU result / store data)
//   - ls_funct3_e     : load/store size+sign encodings carried in funct3
//   - ex_mem_entry_t  : one buffered ALU result with its memory controls
package ex_mem_stage_pkg;

    localparam int EX_DATA_W = 32;

    typedef enum logic [2:0] {
        F3_LB  = 3'd0,
        F3_LH  = 3'd1,
        F3_LW  = 3'd2,
        F3_LBU = 3'd4,
        F3_LHU = 3'd5
    } ls_funct3_e;

    typedef struct packed {
        logic [EX_DATA_W-1:0] result;
        logic [4:0]           rd;
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_write;
        logic [EX_DATA_W-1:0] store_data;
        logic [2:0]           funct3;
    } ex_mem_entry_t;

endpackage

// File: rtl/ex_mem_fifo.sv
// ex_mem_fifo
//   Generic DEPTH-entry circular buffer with valid/ready on both sides and
//   a synchronous flush. Storage, write pointer and count are exported so
//   the owner can scan in-flight entries (e.g. for forwarding).
// Ports:
//   clk, reset_n          clock, async active-low reset
//   i_flush               drop everything at the next edge; blocks push/pop
//   i_valid/o_ready/i_data   write side (o_ready from registered count only)
//   o_valid/i_ready/o_data   read side (o_data holds last popped when empty)
//   o_mem, o_wr_ptr, o_count raw storage view for the owner
module ex_mem_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_flush,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [W-1:0]                 i_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [W-1:0]                 o_data,
    output logic [DEPTH-1:0][W-1:0]      o_mem,
    output logic [$clog2(DEPTH)-1:0]     o_wr_ptr,
    output logic [$clog2(DEPTH):0]       o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][W-1:0] r_mem;
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;
    logic [W-1:0]            r_hold;
    logic                    w_push;
    logic                    w_pop;

    assign o_ready = (r_count != CW'(DEPTH));
    assign o_valid = (r_count != '0);
    assign w_push  = i_valid & o_ready & ~i_flush;
    assign w_pop   = o_valid & i_ready & ~i_flush;

    // When empty the head slot may be stale or overwritten by a later push,
    // so the last popped value is kept separately for a stable output.
    assign o_data   = o_valid ? r_mem[r_rd_ptr] : r_hold;
    assign o_mem    = r_mem;
    assign o_wr_ptr = r_wr_ptr;
    assign o_count  = r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_hold   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_hold   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage
//   EX/MEM pipeline stage: buffers ALU results (with rd and memory controls)
//   in a small FIFO, hands them to MEM/WB over valid/ready, and reports the
//   youngest in-flight register writer for operand forwarding.
// Ports:
//   clk, reset_n                    clock, async active-low reset
//   in_valid/in_ready + fields      ALU-side handshake and entry fields
//   flush                           squash buffered and incoming entries
//   out_valid/out_ready + out_*     MEM-side handshake and head fields
//   fwd_valid/fwd_rd/fwd_data       youngest qualifying writer
//   load_hazard                     that writer is a load (fwd_data = address)
//   occupancy                       number of buffered entries
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W = EX_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        alu_result,
    input  logic [4:0]               rd_addr,
    input  logic                     reg_write,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [DATA_W-1:0]        store_data,
    input  logic [2:0]               funct3,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_result,
    output logic [4:0]               out_rd,
    output logic                     out_reg_write,
    output logic                     out_mem_read,
    output logic                     out_mem_write,
    output logic [DATA_W-1:0]        out_store_data,
    output logic [2:0]               out_funct3,
    output logic                     fwd_valid,
    output logic [4:0]               fwd_rd,
    output logic [DATA_W-1:0]        fwd_data,
    output logic                     load_hazard,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Same layout as ex_mem_entry_t, sized by this instance's DATA_W.
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [4:0]        rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [DATA_W-1:0] store_data;
        logic [2:0]        funct3;
    } ent_t;

    localparam int EW = $bits(ent_t);

    ent_t                     w_in_ent;
    ent_t                     w_head;
    logic [DEPTH-1:0][EW-1:0] w_mem;
    logic [PW-1:0]            w_wr_ptr;
    logic [CW-1:0]            w_count;

    assign w_in_ent = '{result:     alu_result,
                        rd:         rd_addr,
                        reg_write:  reg_write,
                        mem_read:   mem_read,
                        mem_write:  mem_write,
                        store_data: store_data,
                        funct3:     funct3};

    ex_mem_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_flush  (flush),
        .i_valid  (in_valid),
        .o_ready  (in_ready),
        .i_data   (w_in_ent),
        .o_valid  (out_valid),
        .i_ready  (out_ready),
        .o_data   (w_head),
        .o_mem    (w_mem),
        .o_wr_ptr (w_wr_ptr),
        .o_count  (w_count)
    );

    assign out_result     = w_head.result;
    assign out_rd         = w_head.rd;
    assign out_reg_write  = w_head.reg_write;
    assign out_mem_read   = w_head.mem_read;
    assign out_mem_write  = w_head.mem_write;
    assign out_store_data = w_head.store_data;
    assign out_funct3     = w_head.funct3;
    assign occupancy      = w_count;

    // Forwarding scan: walk from the oldest live slot (wr_ptr-count) to the
    // youngest (wr_ptr-1); each later qualifying hit overrides an earlier
    // one, so the youngest qualifying writer wins. Age k is live iff k<=count.
    logic          w_fwd_hit;
    ent_t          w_fwd_ent;
    ent_t          w_cand;
    logic [PW-1:0] w_slot;

    always_comb begin
        w_fwd_hit = 1'b0;
        w_fwd_ent = '0;
        w_cand    = '0;
        w_slot    = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            w_slot = w_wr_ptr - PW'(k);
            w_cand = w_mem[w_slot];
            if ((CW'(k) <= w_count) && w_cand.reg_write && (w_cand.rd != 5'd0)) begin
                w_fwd_hit = 1'b1;
                w_fwd_ent = w_cand;
            end
        end
    end

    assign fwd_valid   = w_fwd_hit;
    assign fwd_rd      = w_fwd_ent.rd;
    assign fwd_data    = w_fwd_ent.result;
    assign load_hazard = w_fwd_hit & w_fwd_ent.mem_read;

endmodule
